// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: device-side UART responder for the remote command link.
// Two received bytes (high byte first) form a 16-bit command. An 8-bit
// response is sent back on request. Serial format is 8N1, LSB first, idle
// high. The receive and transmit paths run independently.
module uart_cmd_wrapper #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {RX_IDLE, RX_RECV}    rx_state_e;
    typedef enum logic {BYTE_HIGH, BYTE_LOW} byte_state_e;
    typedef enum logic {TX_IDLE, TX_XMIT}    tx_state_e;

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic             rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
    rx_state_e        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_baud_reg;
    logic [3:0]       rx_bit_reg;
    logic [7:0]       rx_shift_reg;
    logic             rx_fall, rx_start, rx_sample, rx_abort, rx_rdy;

    assign rx_fall = rx_prev_reg & ~rx_sync2_reg;

    // Synchronise RX; flops reset to idle-high so reset release is not seen as a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
        end else begin
            rx_sync1_reg <= RX;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_reg <= RX_IDLE;
        else        rx_state_reg <= rx_state_next;
    end

    // Receiver next state: leave RECV after the stop sample or on a glitched start bit
    always_comb begin
        rx_state_next = rx_state_reg;
        case (rx_state_reg)
            RX_IDLE: if (rx_start) rx_state_next = RX_RECV;
            RX_RECV: if (rx_abort || rx_rdy) rx_state_next = RX_IDLE;
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // Receiver strobes: start detect, bit-centre sample, abort and byte-ready
    always_comb begin
        rx_start  = 1'b0;
        rx_sample = 1'b0;
        rx_abort  = 1'b0;
        rx_rdy    = 1'b0;
        if (rx_state_reg == RX_IDLE) begin
            rx_start = rx_fall;
        end else begin
            rx_sample = (rx_baud_reg == '0);
            rx_abort  = rx_sample && (rx_bit_reg == 4'd0) && rx_sync2_reg;
            rx_rdy    = rx_sample && (rx_bit_reg == 4'd9);
        end
    end

    // Receiver datapath: half-bit delay to the start-bit centre, then one sample per bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_baud_reg  <= '0;
            rx_bit_reg   <= 4'd0;
            rx_shift_reg <= 8'h00;
        end else if (rx_start) begin
            rx_baud_reg <= HALF_LAST;
            rx_bit_reg  <= 4'd0;
        end else if (rx_sample) begin
            rx_baud_reg <= BAUD_LAST;
            rx_bit_reg  <= rx_bit_reg + 4'd1;
            // Only the eight data samples enter the shifter; start and stop are not stored
            if (rx_bit_reg != 4'd0 && rx_bit_reg != 4'd9)
                rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
        end else if (rx_state_reg == RX_RECV) begin
            rx_baud_reg <= rx_baud_reg - CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Byte pairing into a 16-bit command
    // ------------------------------------------------------------------
    byte_state_e byte_state_reg, byte_state_next;
    logic [15:0] cmd_reg;
    logic        cmd_rdy_reg;
    logic        load_hi, load_lo, start_clear;

    // Byte-pair state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) byte_state_reg <= BYTE_HIGH;
        else        byte_state_reg <= byte_state_next;
    end

    // Byte-pair next state: alternate on each received byte
    always_comb begin
        byte_state_next = byte_state_reg;
        case (byte_state_reg)
            BYTE_HIGH: if (rx_rdy) byte_state_next = BYTE_LOW;
            BYTE_LOW:  if (rx_rdy) byte_state_next = BYTE_HIGH;
            default:   byte_state_next = BYTE_HIGH;
        endcase
    end

    // Byte-pair strobes; a new start bit while awaiting a high byte retires the old command
    always_comb begin
        load_hi     = 1'b0;
        load_lo     = 1'b0;
        start_clear = 1'b0;
        if (byte_state_reg == BYTE_HIGH) begin
            load_hi     = rx_rdy;
            start_clear = rx_start;
        end else begin
            load_lo = rx_rdy;
        end
    end

    // Command register and ready flag; setting takes priority over clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_reg     <= 16'h0000;
            cmd_rdy_reg <= 1'b0;
        end else begin
            if (load_hi) cmd_reg[15:8] <= rx_shift_reg;
            if (load_lo) cmd_reg[7:0]  <= rx_shift_reg;
            if (load_lo)
                cmd_rdy_reg <= 1'b1;
            else if (clr_cmd_rdy || start_clear)
                cmd_rdy_reg <= 1'b0;
        end
    end

    assign cmd     = cmd_reg;
    assign cmd_rdy = cmd_rdy_reg;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    tx_state_e        tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_baud_reg;
    logic [3:0]       tx_bit_reg;
    logic [8:0]       tx_shift_reg;
    logic             tx_reg, tx_done_reg;
    logic             tx_load, tx_tick, tx_last;

    // Transmitter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_reg <= TX_IDLE;
        else        tx_state_reg <= tx_state_next;
    end

    // Transmitter next state: trmt is only honoured while idle
    always_comb begin
        tx_state_next = tx_state_reg;
        case (tx_state_reg)
            TX_IDLE: if (tx_load) tx_state_next = TX_XMIT;
            TX_XMIT: if (tx_last) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // Transmitter strobes: accept, bit-period boundary, end of stop bit
    always_comb begin
        tx_load = 1'b0;
        tx_tick = 1'b0;
        tx_last = 1'b0;
        if (tx_state_reg == TX_IDLE) begin
            tx_load = trmt;
        end else begin
            tx_tick = (tx_baud_reg == '0);
            tx_last = tx_tick && (tx_bit_reg == 4'd9);
        end
    end

    // Transmitter datapath; the start bit goes straight to TX, the shifter holds data and stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_baud_reg  <= '0;
            tx_bit_reg   <= 4'd0;
            tx_shift_reg <= 9'h1FF;
            tx_reg       <= 1'b1;
            tx_done_reg  <= 1'b0;
        end else if (tx_load) begin
            tx_shift_reg <= {1'b1, resp};
            tx_reg       <= 1'b0;
            tx_baud_reg  <= BAUD_LAST;
            tx_bit_reg   <= 4'd0;
            tx_done_reg  <= 1'b0;
        end else if (tx_last) begin
            tx_reg      <= 1'b1;
            tx_done_reg <= 1'b1;
        end else if (tx_tick) begin
            tx_reg       <= tx_shift_reg[0];
            tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
            tx_baud_reg  <= BAUD_LAST;
            tx_bit_reg   <= tx_bit_reg + 4'd1;
        end else if (tx_state_reg == TX_XMIT) begin
            tx_baud_reg <= tx_baud_reg - CNT_ONE;
        end
    end

    assign TX      = tx_reg;
    assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Testbench for uart_cmd_wrapper with BAUD_DIV=16: a serial driver on RX,
// a bit-timing model and a serial decoder on TX, expectations computed
// from the frame format.
module tb_uart_cmd_wrapper;

    localparam int BAUD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        trmt = 1'b0;
    logic        tx_done;

    int check_cnt = 0;
    int pass_cnt  = 0;

    uart_cmd_wrapper #(.BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Hold one serial bit level on RX for a full bit period
    task automatic drive_bit(input logic v);
        RX = v;
        repeat (BAUD) @(negedge clk);
    endtask

    // Send one 8N1 byte; report cmd_rdy/cmd after the start bit and the first stop-bit cycle with cmd_rdy=1
    task automatic send_byte(input logic [7:0] b, output int rdy_at,
                             output logic rdy_after_start, output logic [15:0] cmd_after_start);
        drive_bit(1'b0);
        rdy_after_start = cmd_rdy;
        cmd_after_start = cmd;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        RX = 1'b1;
        rdy_at = -1;
        for (int j = 1; j <= BAUD; j++) begin
            @(negedge clk);
            if (rdy_at < 0 && cmd_rdy === 1'b1) rdy_at = j;
        end
    endtask

    // Serial decoder on TX: find the start bit, sample each bit at its centre
    task automatic tx_capture(output logic [7:0] got, output logic found, output logic stop_bit);
        int wait_cnt;
        got = 8'h00;
        stop_bit = 1'b0;
        wait_cnt = 0;
        while (TX !== 1'b0 && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        found = (TX === 1'b0);
        if (found) begin
            repeat (BAUD / 2 - 1) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                got[i] = TX;
            end
            repeat (BAUD) @(negedge clk);
            stop_bit = TX;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RX = 1'b1;
        repeat (3) @(negedge clk);
        check_cnt++; if (TX !== 1'b1) $display("FAIL reset_tx: got %b expected 1", TX); else pass_cnt++;
        check_cnt++; if (cmd !== 16'h0000) $display("FAIL reset_cmd: got %h expected 0000", cmd); else pass_cnt++;
        check_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL reset_cmd_rdy: got %b expected 0", cmd_rdy); else pass_cnt++;
        check_cnt++; if (tx_done !== 1'b0) $display("FAIL reset_tx_done: got %b expected 0", tx_done); else pass_cnt++;
        rst_n = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            check_cnt++;
            if (TX !== 1'b1 || cmd_rdy !== 1'b0 || cmd !== 16'h0000)
                $display("FAIL reset_idle cycle %0d: TX=%b cmd_rdy=%b cmd=%h expected 1/0/0000", c, TX, cmd_rdy, cmd);
            else pass_cnt++;
        end
        $display("test_reset done");
    endtask

    task automatic test_cmd_pair();
        int rdy_at; logic ras; logic [15:0] cas;
        send_byte(8'h20, rdy_at, ras, cas);
        check_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL pair_first_byte_rdy: got %b expected 0", cmd_rdy); else pass_cnt++;
        send_byte(8'h01, rdy_at, ras, cas);
        check_cnt++; if (rdy_at < 9 || rdy_at > 13) $display("FAIL pair_rdy_timing: got stop cycle %0d expected 9..13", rdy_at); else pass_cnt++;
        check_cnt++; if (cmd !== 16'h2001) $display("FAIL pair_cmd: got %h expected 2001", cmd); else pass_cnt++;
        repeat (20) @(negedge clk);
        check_cnt++; if (cmd_rdy !== 1'b1) $display("FAIL pair_rdy_held: got %b expected 1", cmd_rdy); else pass_cnt++;
        pulse_clr();
        check_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL pair_clr: got %b expected 0", cmd_rdy); else pass_cnt++;
        check_cnt++; if (cmd !== 16'h2001) $display("FAIL pair_cmd_after_clr: got %h expected 2001", cmd); else pass_cnt++;
        $display("test_cmd_pair cmd=%h", cmd);
    endtask

    // Per-cycle check of a TX frame; optional second trmt at cycle second_at must be ignored
    task automatic test_tx_frame(input logic [7:0] r, input int second_at, input logic [7:0] second_r);
        int   rises;
        logic prev_done;
        logic exp_tx, exp_done;
        int   k;
        @(negedge clk);
        resp = r;
        trmt = 1'b1;
        prev_done = tx_done;
        rises = 0;
        for (int m = 1; m <= 175; m++) begin
            @(negedge clk);
            if (m == 1) trmt = 1'b0;
            if (second_at > 0 && m == second_at) begin
                resp = second_r;
                trmt = 1'b1;
            end
            if (second_at > 0 && m == second_at + 1) trmt = 1'b0;
            k = (m - 1) / BAUD;
            if (k == 0) exp_tx = 1'b0;
            else if (k >= 9) exp_tx = 1'b1;
            else exp_tx = r[k-1];
            exp_done = (m > 10 * BAUD);
            if (tx_done === 1'b1 && prev_done !== 1'b1) rises++;
            prev_done = tx_done;
            check_cnt++;
            if (TX !== exp_tx) $display("FAIL tx_bit cycle %0d: got %b expected %b", m, TX, exp_tx); else pass_cnt++;
            check_cnt++;
            if (tx_done !== exp_done) $display("FAIL tx_done cycle %0d: got %b expected %b", m, tx_done, exp_done); else pass_cnt++;
        end
        check_cnt++; if (rises != 1) $display("FAIL tx_done_rises: got %0d expected 1", rises); else pass_cnt++;
        $display("test_tx_frame resp=%h second_at=%0d rises=%0d", r, second_at, rises);
    endtask

    task automatic test_clear_on_start();
        int rdy_at; logic ras; logic [15:0] cas;
        send_byte(8'h3F, rdy_at, ras, cas);
        send_byte(8'hFF, rdy_at, ras, cas);
        check_cnt++; if (cmd !== 16'h3FFF || cmd_rdy !== 1'b1) $display("FAIL start_pair1: got %h/%b expected 3fff/1", cmd, cmd_rdy); else pass_cnt++;
        repeat (10) @(negedge clk);
        send_byte(8'h12, rdy_at, ras, cas);
        check_cnt++; if (ras !== 1'b0) $display("FAIL start_clears_rdy: got %b expected 0", ras); else pass_cnt++;
        check_cnt++; if (cas !== 16'h3FFF) $display("FAIL start_cmd_stable: got %h expected 3fff", cas); else pass_cnt++;
        check_cnt++; if (cmd !== 16'h12FF || cmd_rdy !== 1'b0) $display("FAIL start_high_only: got %h/%b expected 12ff/0", cmd, cmd_rdy); else pass_cnt++;
        send_byte(8'h34, rdy_at, ras, cas);
        check_cnt++; if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) $display("FAIL start_pair2: got %h/%b expected 1234/1", cmd, cmd_rdy); else pass_cnt++;
        pulse_clr();
        $display("test_clear_on_start cmd=%h", cmd);
    endtask

    // clr_cmd_rdy held through the completing stop bit: set wins, so cmd_rdy shows for exactly one cycle
    task automatic test_set_wins();
        int rdy_at; logic ras; logic [15:0] cas;
        int ones;
        send_byte(8'h55, rdy_at, ras, cas);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(((8'hAA >> i) & 8'h01) != 8'h00);
        RX = 1'b1;
        clr_cmd_rdy = 1'b1;
        ones = 0;
        for (int j = 0; j < BAUD; j++) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) ones++;
        end
        clr_cmd_rdy = 1'b0;
        check_cnt++; if (ones != 1) $display("FAIL set_wins_cycles: got %0d expected 1", ones); else pass_cnt++;
        check_cnt++; if (cmd !== 16'h55AA) $display("FAIL set_wins_cmd: got %h expected 55aa", cmd); else pass_cnt++;
        $display("test_set_wins ones=%0d cmd=%h", ones, cmd);
    endtask

    task automatic test_async_reset();
        int rdy_at; logic ras; logic [15:0] cas;
        @(negedge clk);
        resp = 8'h00;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check_cnt++; if (TX !== 1'b0) $display("FAIL areset_pre_tx: got %b expected 0", TX); else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        check_cnt++; if (TX !== 1'b1) $display("FAIL areset_tx: got %b expected 1", TX); else pass_cnt++;
        check_cnt++; if (cmd !== 16'h0000) $display("FAIL areset_cmd: got %h expected 0000", cmd); else pass_cnt++;
        check_cnt++; if (cmd_rdy !== 1'b0 || tx_done !== 1'b0) $display("FAIL areset_flags: got %b/%b expected 0/0", cmd_rdy, tx_done); else pass_cnt++;
        RX = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_cnt++; if (TX !== 1'b1) $display("FAIL areset_tx_idle: got %b expected 1", TX); else pass_cnt++;
        send_byte(8'h41, rdy_at, ras, cas);
        check_cnt++; if (cmd_rdy !== 1'b0) $display("FAIL areset_first_rdy: got %b expected 0", cmd_rdy); else pass_cnt++;
        send_byte(8'h22, rdy_at, ras, cas);
        check_cnt++; if (cmd !== 16'h4122 || cmd_rdy !== 1'b1) $display("FAIL areset_pair: got %h/%b expected 4122/1", cmd, cmd_rdy); else pass_cnt++;
        pulse_clr();
        $display("test_async_reset cmd=%h", cmd);
    endtask

    // Random command pairs received while a random response is transmitted
    task automatic test_full_duplex();
        logic [7:0]  b0, b1, r, got;
        logic        found, stop_bit;
        logic [15:0] exp_cmd;
        int          rdy_at0, rdy_at1;
        logic        ras; logic [15:0] cas;
        for (int it = 0; it < 4; it++) begin
            b0 = 8'($urandom_range(0, 255));
            b1 = 8'($urandom_range(0, 255));
            r  = 8'($urandom_range(0, 255));
            exp_cmd = {b0, b1};
            fork
                begin
                    send_byte(b0, rdy_at0, ras, cas);
                    send_byte(b1, rdy_at1, ras, cas);
                end
                begin
                    @(negedge clk);
                    resp = r;
                    trmt = 1'b1;
                    @(negedge clk);
                    trmt = 1'b0;
                    tx_capture(got, found, stop_bit);
                end
            join
            check_cnt++; if (!found || got !== r) $display("FAIL duplex_tx it %0d: got %h found=%b expected %h", it, got, found, r); else pass_cnt++;
            check_cnt++; if (stop_bit !== 1'b1) $display("FAIL duplex_stop it %0d: got %b expected 1", it, stop_bit); else pass_cnt++;
            check_cnt++; if (tx_done !== 1'b1) $display("FAIL duplex_tx_done it %0d: got %b expected 1", it, tx_done); else pass_cnt++;
            check_cnt++; if (cmd !== exp_cmd || cmd_rdy !== 1'b1) $display("FAIL duplex_cmd it %0d: got %h/%b expected %h/1", it, cmd, cmd_rdy, exp_cmd); else pass_cnt++;
            check_cnt++; if (rdy_at1 < 9 || rdy_at1 > 13) $display("FAIL duplex_rdy_timing it %0d: got %0d expected 9..13", it, rdy_at1); else pass_cnt++;
            $display("test_full_duplex it=%0d cmd=%h resp=%h got=%h", it, cmd, r, got);
            pulse_clr();
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_cmd_pair();
        test_tx_frame(8'hA5, 0, 8'h00);
        test_tx_frame(8'hA5, 50, 8'h3C);
        test_clear_on_start();
        test_set_wins();
        test_async_reset();
        test_full_duplex();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
